rotator_tx_serializer: RTL and testbench
========================================

# rotator_tx_serializer

Downstream stage of the 8-bit bitwise rotator. Accepts the rotator's parallel `data_out` word through a valid/ready handshake and transmits it as an asynchronous serial frame on a single line: start bit, data bits in selectable order, optional even parity, and one stop bit. Each bit is held for a programmable number of clock cycles. Signals completion with a one-cycle `done` pulse and supports back-to-back frames.

## Interface
Parameters:
- `WIDTH`, default 8: data word width; must be ≥2.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to transmit, normally the rotator's `data_out`.
- `load_valid`  in  1  upstream has a word on `data_in`.
- `load_ready`  out  1  block can accept a word; combinational, `(state==IDLE) && !reset`.
- `lsb_first`  in  1  1 = send bit 0 first; 0 = send bit WIDTH-1 first.
- `parity_en`  in  1  1 = insert even-parity bit after the data bits.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; high from the cycle after accept through the end of the stop bit.
- `done`  out  1  registered; one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: a transfer occurs on a rising edge where `load_valid && load_ready`. At that edge:
  - Capture `data_in`, `lsb_first` and `parity_en` into internal registers. Later input changes do not affect the frame in flight.
  - Go to START.
- START: `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Shift out WIDTH bits from the captured word, each held CLKS_PER_BIT cycles.
  - Order is set by the captured `lsb_first`.
  - After the last bit, go to PARITY if captured `parity_en`=1, otherwise go to STOP.
- PARITY: `tx_out` = XOR of all captured data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles, then go to IDLE and assert `done` for exactly one cycle.
- IDLE: `tx_out`=1, `busy`=0.
- Counters:
  - Cycle counter `$clog2(CLKS_PER_BIT)` bits wide (minimum 1). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit index counts 0..WIDTH-1.
  - No other wrap behaviour is permitted.
- Back-to-back frames:
  - `load_ready` is high in the cycle where `done`=1.
  - A word accepted at the following edge starts its START bit immediately. There is no extra idle bit.
- `load_valid` while busy is ignored. `load_ready`=0 then, and nothing is captured.
- Reset (any cycle, including mid-frame):
  - On the next edge: state IDLE, `tx_out`=1, `busy`=0, `done`=0, counters 0, shift register 0.
  - The frame is abandoned and no `done` is generated.
  - `load_ready`=0 while `reset` is high.

## Timing
- Accept edge E0. Start bit occupies the cycles after edges E0..E0+CLKS_PER_BIT-1.
- Frame length: N = (WIDTH + 2 + parity_en) × CLKS_PER_BIT cycles.
- `done`=1 in the cycle following edge E0+N. `busy` falls at that same edge.
- `busy` = 1 for exactly N cycles per frame.
- Latency from accept to first line transition (high→low): 1 edge.
- Throughput with continuous `load_valid`: one frame per N+1 cycles. Accept occurs in the `done` cycle.

## Test plan
- Reset values:
  - Stimulus: hold `reset`=1 for 2 cycles with `load_valid`=1.
  - Required: `tx_out`=1, `busy`=0, `done`=0, `load_ready`=0; no frame starts after release until an accept.
- LSB-first, no parity:
  - Stimulus: `data_in`=8'b10110011, `lsb_first`=1, `parity_en`=0, CLKS_PER_BIT=4.
  - Required line sequence, 4 cycles each: 0,1,1,0,0,1,1,0,1,1. Total 40 busy cycles, then one `done` pulse.
- MSB-first with parity:
  - Stimulus: same word, `lsb_first`=0, `parity_en`=1.
  - Required sequence: 0,1,0,1,1,0,0,1,1,1(parity),1(stop). Total 44 cycles.
- Input isolation:
  - Stimulus: change `data_in` to 8'h00 and toggle `lsb_first` one cycle after accept.
  - Required: transmitted frame is unchanged from the previous scenario.
- Back-to-back:
  - Stimulus: hold `load_valid`=1 with 8'hA5 then 8'h3C.
  - Required: second start bit begins the cycle after the `done` cycle; `busy` has a single-cycle low gap; both frames decode correctly.
- Mid-frame reset:
  - Stimulus: assert `reset` during the 3rd data bit.
  - Required: next cycle `tx_out`=1, `busy`=0, no `done`; a new accept afterwards transmits a complete, correct frame.

Source files
------------

// File: rtl/rotator_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rotator_tx_serializer
// Purpose  : Serialises a rotator output word as start/data/parity/stop frame.
// Revision : 1.0 - initial release
// ============================================================================
module rotator_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             lsb_first,
    input  logic             parity_en,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = $clog2(WIDTH);

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_bit_idx;
    logic [WIDTH-1:0]   r_shift;
    logic               r_lsb_first;
    logic               r_parity_en;
    logic               r_parity;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_bit_end;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_shift_nxt;

    assign load_ready = (r_state == c_IDLE) && !reset;
    assign w_accept   = load_valid && load_ready;
    assign w_bit_end  = (r_cnt == c_cnt_max);

    // The captured word is consumed from whichever end goes out first.
    assign w_next_bit  = r_lsb_first ? r_shift[0] : r_shift[WIDTH-1];
    assign w_shift_nxt = r_lsb_first ? (r_shift >> 1) : (r_shift << 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_lsb_first <= 1'b0;
            r_parity_en <= 1'b0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_shift     <= data_in;
                        r_lsb_first <= lsb_first;
                        r_parity_en <= parity_en;
                        r_parity    <= ^data_in;
                        r_cnt       <= '0;
                        r_bit_idx   <= '0;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_next_bit;
                        r_shift   <= w_shift_nxt;
                        r_state   <= c_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_idx_max) begin
                            r_bit_idx <= '0;
                            if (r_parity_en) begin
                                r_tx    <= r_parity;
                                r_state <= c_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_idx_one;
                            r_tx      <= w_next_bit;
                            r_shift   <= w_shift_nxt;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= c_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rotator_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotator_tx_serializer
// Purpose  : Self-checking bench: directed frame table plus random frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotator_tx_serializer;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         lsb_first;
    logic         parity_en;
    logic         tx_out;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    rotator_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lsb_first  (lsb_first),
        .parity_en  (parity_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         lsb;
        logic         par;
        bit           mutate;
        bit           b2b;
        int           nbits;
        logic [15:0]  seq;    // line bits in time order, leftmost sent first
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line content built directly from the frame definition.
    function automatic void model_frame(input logic [W-1:0] d, input logic l, input logic p,
                                        output logic [15:0] e, output int nb);
        int idx;
        e    = '0;
        e[0] = 1'b0;
        for (int i = 0; i < W; i++)
            e[1+i] = l ? d[i] : d[W-1-i];
        idx = W + 1;
        if (p) begin
            e[idx] = ($countones(d) % 2) == 1;
            idx++;
        end
        e[idx] = 1'b1;
        nb = idx + 1;
    endfunction

    // Called just after a negedge with the DUT ready; returns in the done cycle.
    task automatic run_frame(input logic [W-1:0] d, input logic l, input logic p,
                             input logic [15:0] e, input int nb, input bit mutate,
                             input string nm);
        data_in    = d;
        lsb_first  = l;
        parity_en  = p;
        load_valid = 1'b1;
        #1;
        chk({nm, "_ready"}, {31'd0, load_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (mutate) begin
            data_in   = '0;
            lsb_first = ~l;
            parity_en = ~p;
        end
        for (int k = 0; k < nb * C; k++) begin
            chk($sformatf("%s_cyc%0d", nm, k), {28'd0, tx_out, busy, done, load_ready},
                {28'd0, e[k / C], 1'b1, 1'b0, 1'b0});
            @(negedge clk);
        end
        chk({nm, "_done"}, {28'd0, tx_out, busy, done, load_ready}, {28'd0, 4'b1011});
    endtask

    vec_t        tbl[4];
    logic [15:0] e;
    int          nb;
    bit          seen_done;

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'b10110011, 1'b1, 1'b0, 1'b0, 1'b0, 10, 16'(10'b0110011011)};
        tbl[1] = '{8'b10110011, 1'b0, 1'b1, 1'b1, 1'b0, 11, 16'(11'b01011001111)};
        tbl[2] = '{8'hA5,       1'b1, 1'b1, 1'b0, 1'b1, 11, 16'(11'b01010010101)};
        tbl[3] = '{8'h3C,       1'b0, 1'b0, 1'b0, 1'b0, 10, 16'(10'b0001111001)};

        // Reset with load_valid asserted: nothing may be accepted.
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        lsb_first  = 1'b1;
        parity_en  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_state", {28'd0, tx_out, busy, done, load_ready}, {28'd0, 4'b1000});
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {28'd0, tx_out, busy, done, load_ready}, {28'd0, 4'b1001});

        for (int i = 0; i < 4; i++) begin
            e = '0;
            for (int k = 0; k < tbl[i].nbits; k++)
                e[k] = tbl[i].seq[tbl[i].nbits-1-k];
            run_frame(tbl[i].data, tbl[i].lsb, tbl[i].par, e, tbl[i].nbits,
                      tbl[i].mutate, $sformatf("vec%0d", i));
            if (!tbl[i].b2b) begin
                load_valid = 1'b0;
                @(negedge clk);
                chk($sformatf("vec%0d_idle", i), {28'd0, tx_out, busy, done, load_ready},
                    {28'd0, 4'b1001});
            end
        end

        // Reset during the third data bit abandons the frame.
        data_in    = 8'h5A;
        lsb_first  = 1'b1;
        parity_en  = 1'b1;
        load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_state", {28'd0, tx_out, busy, done, load_ready}, {28'd0, 4'b1000});
        reset     = 1'b0;
        seen_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy || !tx_out) seen_done = 1'b1;
        end
        chk("midreset_quiet", {31'd0, seen_done}, 32'd0);
        model_frame(8'h5A, 1'b1, 1'b1, e, nb);
        run_frame(8'h5A, 1'b1, 1'b1, e, nb, 1'b0, "after_reset");
        load_valid = 1'b0;
        @(negedge clk);

        // Random frames, randomly back-to-back or separated by idle gaps.
        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] d;
            logic l, p;
            d = W'($urandom);
            l = 1'($urandom);
            p = 1'($urandom);
            model_frame(d, l, p, e, nb);
            run_frame(d, l, p, e, nb, 1'b1, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 0) begin
                load_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk($sformatf("rnd%0d_gap", n), {28'd0, tx_out, busy, done, load_ready},
                        {28'd0, 4'b1001});
                end
            end
        end
        load_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
